// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int prescaler(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rxd synchroniser, 3-sample history with majority vote and
// falling-edge detect; every flop resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic bit_voted,
  output logic fall
);
  import uart_pkg::*;

  logic       s1;
  logic       s2;
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= 3'b111;
    end else begin
      s1   <= rxd;
      s2   <= s1;
      hist <= {hist[1:0], s2};
    end
  end

  assign bit_voted = (hist[0] & hist[1]) |
                     (hist[0] & hist[2]) |
                     (hist[1] & hist[2]);

  // hist[0] is the previous synced bit
  assign fall = hist[0] & ~s2;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: width, parity and stop bits set by
// parameters, mid-bit majority sampling, parity/framing flags.
module uart_rx_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);
  import uart_pkg::*;

  localparam int PRESCALER = prescaler(CLK_FREQ_HZ, BAUDRATE);
  localparam int CW = $clog2(PRESCALER);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] MID = CW'(PRESCALER / 2);
  localparam logic [CW-1:0] TOP = CW'(PRESCALER - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (PRESCALER < 4) begin : g_bad_prescaler
    $error("uart_rx_cfg: PRESCALER must be >= 4");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_bad_width
    $error("uart_rx_cfg: DATA_WIDTH must be 5..16");
  end

  logic                  voted;
  logic                  fall;
  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  pbit;
  logic                  ferr_acc;
  logic                  mid;
  logic                  xr;
  logic                  par_bad;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .bit_voted (voted),
    .fall      (fall)
  );

  assign mid  = (cnt == MID);
  assign xr   = (^shreg) ^ pbit;
  assign busy = (state != IDLE);

  always_comb begin
    par_bad = 1'b0;
    if (PARITY == 1) par_bad = xr;
    else if (PARITY == 2) par_bad = ~xr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      pbit       <= 1'b0;
      ferr_acc   <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) cnt <= '0;
      else cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (mid) begin
            if (voted) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shreg[idx] <= voted;
            if (idx == LAST) begin
              idx      <= '0;
              ferr_acc <= 1'b0;
              state    <= (PARITY != 0) ? uart_pkg::PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (mid) begin
            pbit  <= voted;
            state <= STOP;
          end
        end
        STOP: begin
          if (mid) begin
            if (idx == LAST_STOP) begin
              data       <= shreg;
              parity_err <= par_bad;
              frame_err  <= ferr_acc | ~voted;
              valid      <= 1'b1;
              idx        <= '0;
              state      <= IDLE;
            end else begin
              ferr_acc <= ferr_acc | ~voted;
              idx      <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: four configurations driven with
// directed frames; a monitor pops expected words on every valid.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_l [4];
  logic vld [4];
  logic perr [4];
  logic ferr [4];
  logic bsy [4];
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcnt [4];
  int vt_last [4];
  int vt_prev [4];
  logic [17:0] exp_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(
    .DATA_WIDTH(8), .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .rxd(rxd_l[0]), .data(d0), .valid(vld[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .busy(bsy[0])
  );

  uart_rx_cfg #(
    .DATA_WIDTH(8), .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .PARITY(1), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .rxd(rxd_l[1]), .data(d1), .valid(vld[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .busy(bsy[1])
  );

  uart_rx_cfg #(
    .DATA_WIDTH(8), .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .PARITY(2), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst), .rxd(rxd_l[2]), .data(d2), .valid(vld[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .busy(bsy[2])
  );

  uart_rx_cfg #(
    .DATA_WIDTH(7), .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .PARITY(0), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst), .rxd(rxd_l[3]), .data(d3), .valid(vld[3]),
    .parity_err(perr[3]), .frame_err(ferr[3]), .busy(bsy[3])
  );

  function automatic logic [15:0] dat(input int i);
    case (i)
      0: return {8'h00, d0};
      1: return {8'h00, d1};
      2: return {8'h00, d2};
      default: return {9'h000, d3};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) begin
          vcnt[i]++;
          vt_prev[i] = vt_last[i];
          vt_last[i] = cyc;
          check($sformatf("busy_at_valid_u%0d", i), 32'(bsy[i]), 0);
          if (exp_q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid_u%0d: got data %0h expected none",
                     i, dat(i));
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("word_u%0d", i),
                  32'({ferr[i], perr[i], dat(i)}), 32'(e));
          end
        end
      end
    end
  end

  task automatic idle(input int i, input int n);
    rxd_l[i] = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input int i, input logic [15:0] d, input int dw,
                      input int haspar, input logic pb, input int nstop,
                      input logic stopv, input int glitch, input int rst_at);
    logic [19:0] fr;
    int n;
    fr = '0;
    n = 1;
    for (int b = 0; b < dw; b++) begin
      fr[n] = d[b];
      n++;
    end
    if (haspar != 0) begin
      fr[n] = pb;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      fr[n] = stopv;
      n++;
    end
    for (int c = 0; c < n * 10; c++) begin
      rxd_l[i] = fr[c / 10] ^ (c == glitch);
      rst = (c == rst_at);
      @(posedge clk);
      if (c == rst_at) begin
        #1;
        check("rst_busy", 32'(bsy[i]), 0);
        check("rst_data", 32'(dat(i)), 0);
        check("rst_valid", 32'(vld[i]), 0);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    int rose;
    int fell_at;
    for (int i = 0; i < 4; i++) begin
      rxd_l[i] = 1'b1;
      vcnt[i] = 0;
      vt_last[i] = 0;
      vt_prev[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_state_u%0d", i),
            32'({dat(i), vld[i], perr[i], ferr[i], bsy[i]}), 0);

    // 8N1 basic word
    exp_q[0].push_back({2'b00, 16'h00A5});
    send(0, 16'hA5, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    idle(0, 20);
    check("t1_valid_count", 32'(vcnt[0]), 1);

    // even / odd parity
    exp_q[1].push_back({2'b00, 16'h0003});
    send(1, 16'h03, 8, 1, 1'b0, 1, 1'b1, -1, -1);
    idle(1, 20);
    exp_q[1].push_back({2'b01, 16'h0003});
    send(1, 16'h03, 8, 1, 1'b1, 1, 1'b1, -1, -1);
    idle(1, 20);
    exp_q[2].push_back({2'b00, 16'h0003});
    send(2, 16'h03, 8, 1, 1'b1, 1, 1'b1, -1, -1);
    idle(2, 20);
    check("t2_valid_count_even", 32'(vcnt[1]), 2);
    check("t2_valid_count_odd", 32'(vcnt[2]), 1);

    // framing error with line held low
    v = vcnt[0];
    exp_q[0].push_back({2'b10, 16'h0055});
    send(0, 16'h55, 8, 0, 1'b0, 1, 1'b0, -1, -1);
    rxd_l[0] = 1'b0;
    repeat (30) @(posedge clk);
    check("t3_one_valid_low", 32'(vcnt[0] - v), 1);
    idle(0, 20);
    check("t3_one_valid_high", 32'(vcnt[0] - v), 1);
    exp_q[0].push_back({2'b00, 16'h0081});
    send(0, 16'h81, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    idle(0, 20);
    check("t3_recovered", 32'(vcnt[0] - v), 2);

    // false start and mid-bit glitch
    v = vcnt[0];
    rose = 0;
    fell_at = 99;
    rxd_l[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      if (k == 2) rxd_l[0] = 1'b1;
      #1;
      if (bsy[0]) rose = 1;
      else if (rose != 0 && fell_at == 99) fell_at = k;
    end
    check("t4_busy_rose", 32'(rose), 1);
    check("t4_busy_dropped_by_9", 32'(fell_at <= 9), 1);
    check("t4_no_valid", 32'(vcnt[0] - v), 0);
    exp_q[0].push_back({2'b00, 16'h00FF});
    send(0, 16'hFF, 8, 0, 1'b0, 1, 1'b1, 44, -1);
    idle(0, 20);
    check("t4_glitch_valid", 32'(vcnt[0] - v), 1);

    // 7 data bits, 2 stop bits, back to back
    v = vcnt[3];
    exp_q[3].push_back({2'b00, 16'h0012});
    exp_q[3].push_back({2'b00, 16'h006D});
    send(3, 16'h12, 7, 0, 1'b0, 2, 1'b1, -1, -1);
    send(3, 16'h6D, 7, 0, 1'b0, 2, 1'b1, -1, -1);
    idle(3, 30);
    check("t5_valid_count", 32'(vcnt[3] - v), 2);
    check("t5_valid_spacing", 32'(vt_last[3] - vt_prev[3]), 100);

    // reset during data bit 4 aborts the frame
    v = vcnt[0];
    send(0, 16'hF0, 8, 0, 1'b0, 1, 1'b1, -1, 53);
    idle(0, 20);
    check("t6_no_valid_aborted", 32'(vcnt[0] - v), 0);
    exp_q[0].push_back({2'b00, 16'h003C});
    send(0, 16'h3C, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    idle(0, 20);
    check("t6_next_frame", 32'(vcnt[0] - v), 1);

    for (int i = 0; i < 4; i++)
      check($sformatf("queue_drained_u%0d", i), 32'(exp_q[i].size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
